// File: rtl/wb_regfile.sv
// Purpose : writeback-stage register file: selects load/ALU data, commits it to the
//           destination register and exposes two asynchronous read ports.
// Latency : reads 0 cycles; write visible after 1 rising edge; wb_*_q flags 1 cycle.
// Backpres: none; a commit is accepted on every rising edge.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   R_data_RAM_MEM_WB         load data from MEM/WB
//   result_ALU_MEM_WB         ALU result from MEM/WB
//   Instruccion_MUX_MEM_WB    destination register number
//   RegWrite_MEM_WB           destination write enable
//   MemToReg_MEM_WB           1 = load data, 0 = ALU result
//   rs_addr/rt_addr           read addresses; rs_data/rt_data read data
//   wb_data                   selected writeback value (combinational)
//   wb_we_q/wb_addr_q/wb_data_q  registered record of the last commit
// Configuration macro: WB_REGFILE_BYPASS_EN (defined = write-first read ports).
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] R_data_RAM_MEM_WB,
    input  logic [DATA_W-1:0] result_ALU_MEM_WB,
    input  logic [4:0]        Instruccion_MUX_MEM_WB,
    input  logic              RegWrite_MEM_WB,
    input  logic              MemToReg_MEM_WB,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we_q,
    output logic [4:0]        wb_addr_q,
    output logic [DATA_W-1:0] wb_data_q
);

    logic [DATA_W-1:0] regs [NREG];
    logic              commit;

    assign wb_data = MemToReg_MEM_WB ? R_data_RAM_MEM_WB : result_ALU_MEM_WB;

    // Writes to register 0 are dropped entirely, including from the wb_*_q record.
    assign commit = RegWrite_MEM_WB && (Instruccion_MUX_MEM_WB != 5'd0);

    // Register 0 and addresses beyond NREG read as zero.
    function automatic logic [DATA_W-1:0] rd_port(input logic [4:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a != 5'd0 && int'(a) < NREG) begin
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && a == Instruccion_MUX_MEM_WB)
                v = wb_data;
            else
                v = regs[a];
`else
            v = regs[a];
`endif
        end
        return v;
    endfunction

    always_comb begin
        rs_data = rd_port(rs_addr);
        rt_data = rd_port(rt_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= '0;
        end else begin
            wb_we_q   <= commit;
            wb_addr_q <= commit ? Instruccion_MUX_MEM_WB : 5'd0;
            wb_data_q <= commit ? wb_data : '0;
            // Gated on commit so unknown data never reaches the array when idle.
            if (commit && int'(Instruccion_MUX_MEM_WB) < NREG)
                regs[Instruccion_MUX_MEM_WB] <= wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Purpose : self-checking bench for wb_regfile against an array-based reference model.
// Latency : model expects writes visible one edge after commit, reads immediate.
// Backpres: not applicable.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ram = '0, alu = '0;
    logic [4:0]  waddr = '0, rs_addr = '0, rt_addr = '0;
    logic        we = 1'b0, m2r = 1'b0;
    logic [31:0] rs_data, rt_data, wb_data, wb_data_q;
    logic        wb_we_q;
    logic [4:0]  wb_addr_q;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk                    (clk),
        .rst                    (rst),
        .R_data_RAM_MEM_WB      (ram),
        .result_ALU_MEM_WB      (alu),
        .Instruccion_MUX_MEM_WB (waddr),
        .RegWrite_MEM_WB        (we),
        .MemToReg_MEM_WB        (m2r),
        .rs_addr                (rs_addr),
        .rt_addr                (rt_addr),
        .rs_data                (rs_data),
        .rt_data                (rt_data),
        .wb_data                (wb_data),
        .wb_we_q                (wb_we_q),
        .wb_addr_q              (wb_addr_q),
        .wb_data_q              (wb_data_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel_val();
        return m2r ? ram : alu;
    endfunction

    function automatic bit commits();
        return we && waddr != 5'd0;
    endfunction

    // What a read port should show before the edge, given current inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && commits() && a == waddr) return sel_val();
        return model[a];
    endfunction

    task automatic drive(input logic w, input logic m, input logic [4:0] a,
                         input logic [31:0] al, input logic [31:0] rm);
        we = w; m2r = m; waddr = a; alu = al; ram = rm;
    endtask

    // Take one edge: update model for a commit and check the registered record.
    task automatic step(input string tag);
        bit          c;
        logic [4:0]  ea;
        logic [31:0] ed;
        c  = commits();
        ea = c ? waddr : 5'd0;
        ed = c ? sel_val() : 32'd0;
        @(posedge clk);
        #1;
        if (c) model[waddr] = ed;
        chk({tag, "_we_q"},   {31'd0, wb_we_q}, {31'd0, c});
        chk({tag, "_addr_q"}, {27'd0, wb_addr_q}, {27'd0, ea});
        chk({tag, "_data_q"}, wb_data_q, ed);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            chk({tag, "_rs"}, rs_data, exp_rd(rs_addr));
            chk({tag, "_rt"}, rt_data, exp_rd(rt_addr));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state, then release away from an edge.
        #2;
        chk("rst_we_q", {31'd0, wb_we_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_all("after_rst");
        chk("after_rst_we_q", {31'd0, wb_we_q}, 32'd0);

        // Write reg5 from the ALU path.
        drive(1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF);
        #1;
        chk("wb_data_alu", wb_data, 32'h0000_1234);
        step("w5");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd5;
        #1;
        chk("r5", rs_data, 32'h0000_1234);

        // Write to reg0 is ignored.
        drive(1'b1, 1'b1, 5'd0, 32'd0, 32'hFFFF_FFFF);
        #1;
        chk("wb_data_ram", wb_data, 32'hFFFF_FFFF);
        step("w0");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd0;
        #1;
        chk("r0", rs_data, 32'd0);

        // Same-cycle read of the register being written.
        drive(1'b1, 1'b0, 5'd9, 32'h11, 32'h0);
        step("w9a");
        drive(1'b1, 1'b0, 5'd9, 32'h22, 32'h0);
        rs_addr = 5'd9; rt_addr = 5'd9;
        #1;
        chk("r9_pre_rs", rs_data, BYP ? 32'h22 : 32'h11);
        chk("r9_pre_rt", rt_data, BYP ? 32'h22 : 32'h11);
        step("w9b");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        chk("r9_post_rs", rs_data, 32'h22);
        chk("r9_post_rt", rt_data, 32'h22);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
            rs_addr = 5'($urandom);
            rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom);
            #1;
            chk("rnd_wb_data", wb_data, sel_val());
            chk("rnd_rs", rs_data, exp_rd(rs_addr));
            chk("rnd_rt", rt_data, exp_rd(rt_addr));
            step("rnd");
        end

        // Idle writes: RegWrite low with random everything else.
        for (int n = 0; n < 10; n++) begin
            drive(1'b0, 1'($urandom), 5'($urandom), $urandom, $urandom);
            step("idle");
        end
        check_all("idle_array");

        // Asynchronous reset between edges after writing reg31.
        drive(1'b1, 1'b0, 5'd31, 32'hA5A5_A5A5, 32'd0);
        step("w31");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd31;
        #1;
        chk("r31", rs_data, 32'hA5A5_A5A5);
        #1;
        rst = 1'b1;
        #1;
        chk("r31_async_clr", rs_data, 32'd0);
        chk("rst_async_we_q", {31'd0, wb_we_q}, 32'd0);
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Write during reset is discarded.
        drive(1'b1, 1'b0, 5'd7, 32'h77, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_we_q", {31'd0, wb_we_q}, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_all("post_rst");

        // First edge after release accepts a write.
        drive(1'b1, 1'b1, 5'd3, 32'd0, 32'h0BAD_F00D);
        step("first_w");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rt_addr = 5'd3;
        #1;
        chk("r3", rt_data, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
